// File: rtl/hazard_pkg.sv
// Shared types and constants for the LEGv8 hazard/stall controller.
package hazard_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MUL_WAIT = 1'b1
   } hz_state_t;

   localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter; wraps modulo 2^CNT_W.
module perf_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (inc_i) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory
// wait freezes and a fixed-latency multiply freeze, plus stall/flush counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MUL_LATENCY = 4,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       ifid_rn,
   input  logic [4:0]       ifid_rm,
   input  logic             id_uses_rn,
   input  logic             id_uses_rm,
   input  logic             br_taken,
   input  logic [4:0]       idex_rd,
   input  logic             idex_memtoreg,
   input  logic             idex_mul,
   input  logic             dmem_busy,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwr_en,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   hz_state_t  state_d, state_q;
   logic [7:0] mcnt_d, mcnt_q;
   logic       load_use;
   logic [4:0] en;

   assign load_use = idex_memtoreg && (idex_rd != XZR) &&
                     ((id_uses_rn && (ifid_rn == idex_rd)) ||
                      (id_uses_rm && (ifid_rm == idex_rd)));

   always_comb begin
      state_d     = state_q;
      mcnt_d      = mcnt_q;
      en          = 5'b11111;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (!reset) begin
         en = 5'b00000;
      end else if (dmem_busy) begin
         en = 5'b00000;
         // The multiply keeps making progress while memory holds the pipe.
         if (state_q == MUL_WAIT && mcnt_q != 8'd0) begin
            mcnt_d = mcnt_q - 8'd1;
         end
      end else if (state_q == RUN && idex_mul) begin
         en      = 5'b00000;
         mcnt_d  = 8'(MUL_LATENCY - 2);
         state_d = MUL_WAIT;
      end else if (state_q == MUL_WAIT && mcnt_q != 8'd0) begin
         en     = 5'b00000;
         mcnt_d = mcnt_q - 8'd1;
      end else begin
         state_d = RUN;
         if (load_use) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX, let EX drain.
            en          = 5'b00111;
            idex_bubble = 1'b1;
         end else if (br_taken) begin
            ifid_flush = 1'b1;
         end
      end
   end

   assign {pc_en, ifid_en, idex_en, exmem_en, memwr_en} = en;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         mcnt_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         mcnt_q  <= mcnt_d;
      end
   end

   perf_counter #(
      .CNT_W(CNT_W)
   ) u_stall_cnt (
      .clk_i  (clk),
      .rst_ni (reset),
      .inc_i  (!pc_en),
      .count_o(stall_cycles)
   );

   perf_counter #(
      .CNT_W(CNT_W)
   ) u_flush_cnt (
      .clk_i  (clk),
      .rst_ni (reset),
      .inc_i  (ifid_flush),
      .count_o(flush_count)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic,
// checked against a cycle-age reference model of the stall rules.
module tb_hazard_ctrl;

   localparam int unsigned L     = 4;
   localparam int unsigned CNT_W = 8;
   localparam int          CMASK = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic [4:0]       ifid_rn, ifid_rm, idex_rd;
   logic             id_uses_rn, id_uses_rm, br_taken;
   logic             idex_memtoreg, idex_mul, dmem_busy;
   logic             pc_en, ifid_en, idex_en, exmem_en, memwr_en;
   logic             ifid_flush, idex_bubble;
   logic [CNT_W-1:0] stall_cycles, flush_count;

   always #5 clk = ~clk;

   hazard_ctrl #(
      .MUL_LATENCY(L),
      .CNT_W      (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ifid_rn      (ifid_rn),
      .ifid_rm      (ifid_rm),
      .id_uses_rn   (id_uses_rn),
      .id_uses_rm   (id_uses_rm),
      .br_taken     (br_taken),
      .idex_rd      (idex_rd),
      .idex_memtoreg(idex_memtoreg),
      .idex_mul     (idex_mul),
      .dmem_busy    (dmem_busy),
      .pc_en        (pc_en),
      .ifid_en      (ifid_en),
      .idex_en      (idex_en),
      .exmem_en     (exmem_en),
      .memwr_en     (memwr_en),
      .ifid_flush   (ifid_flush),
      .idex_bubble  (idex_bubble),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

   typedef struct {
      logic [4:0] en;
      logic       flush;
      logic       bubble;
      int         sc;
      int         fc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model: a multiply is tracked by its age in cycles since it
   // was accepted; it may leave once age >= L-1 and memory is not busy.
   bit m_in_mul = 1'b0;
   int m_age    = 0;
   int m_sc     = 0;
   int m_fc     = 0;

   task automatic model_step();
      exp_t e;
      bit   lu;
      e.sc     = m_sc;
      e.fc     = m_fc;
      e.en     = 5'b11111;
      e.flush  = 1'b0;
      e.bubble = 1'b0;
      if (!reset) begin
         e.en     = 5'b00000;
         e.sc     = 0;
         e.fc     = 0;
         m_in_mul = 1'b0;
         m_age    = 0;
         m_sc     = 0;
         m_fc     = 0;
         sb.push_back(e);
         return;
      end
      lu = idex_memtoreg && idex_rd != 5'd31 &&
           ((id_uses_rn && ifid_rn == idex_rd) || (id_uses_rm && ifid_rm == idex_rd));
      if (dmem_busy) begin
         e.en = 5'b00000;
         if (m_in_mul) m_age++;
      end else if (!m_in_mul && idex_mul) begin
         e.en     = 5'b00000;
         m_in_mul = 1'b1;
         m_age    = 1;
      end else if (m_in_mul && m_age < int'(L) - 1) begin
         e.en = 5'b00000;
         m_age++;
      end else begin
         m_in_mul = 1'b0;
         if (lu) begin
            e.en     = 5'b00111;
            e.bubble = 1'b1;
         end else if (br_taken) begin
            e.flush = 1'b1;
         end
      end
      if (!e.en[4]) m_sc = (m_sc + 1) & CMASK;
      if (e.flush)  m_fc = (m_fc + 1) & CMASK;
      sb.push_back(e);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("enables", int'({pc_en, ifid_en, idex_en, exmem_en, memwr_en}), int'(e.en));
         chk("ifid_flush", int'(ifid_flush), int'(e.flush));
         chk("idex_bubble", int'(idex_bubble), int'(e.bubble));
         chk("stall_cycles", int'(stall_cycles), e.sc);
         chk("flush_count", int'(flush_count), e.fc);
      end
   end

   // One clock cycle of stimulus; called at posedge+1.
   task automatic cyc(input logic rst, input logic busy, input logic mul, input logic mtr,
                      input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                      input logic urn, input logic urm, input logic br);
      reset         = rst;
      dmem_busy     = busy;
      idex_mul      = mul;
      idex_memtoreg = mtr;
      idex_rd       = rd;
      ifid_rn       = rn;
      ifid_rm       = rm;
      id_uses_rn    = urn;
      id_uses_rm    = urm;
      br_taken      = br;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 1, 2, 1, 1, 0);
   endtask

   initial begin
      reset = 1'b0;
      {dmem_busy, idex_mul, idex_memtoreg, id_uses_rn, id_uses_rm, br_taken} = '0;
      {idex_rd, ifid_rn, ifid_rm} = '0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 5, 5, 5, 1, 1, 1);
      idle(2);
      // Load-use on Rn, then XZR and unused-Rm non-hazards.
      cyc(1, 0, 0, 1, 5, 5, 0, 1, 0, 0);
      idle(1);
      cyc(1, 0, 0, 1, 31, 31, 31, 1, 1, 0);
      cyc(1, 0, 0, 1, 7, 1, 7, 1, 0, 0);
      cyc(1, 0, 0, 1, 7, 1, 7, 1, 1, 0);
      // Branch alone, then branch under load-use followed by the retried branch.
      cyc(1, 0, 0, 0, 0, 1, 2, 1, 1, 1);
      cyc(1, 0, 0, 1, 3, 3, 0, 1, 1, 1);
      cyc(1, 0, 0, 0, 0, 3, 0, 1, 1, 1);
      idle(1);
      // Multiply held in EX for its whole latency, then a clean release.
      for (int i = 0; i < int'(L); i++) cyc(1, 0, 1, 0, 0, 1, 2, 1, 1, 0);
      idle(2);
      // Multiply with memory wait on cycles 2..6.
      cyc(1, 0, 1, 0, 0, 1, 2, 1, 1, 0);
      for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0, 0, 1, 2, 1, 1, 0);
      cyc(1, 0, 1, 0, 0, 1, 2, 1, 1, 0);
      idle(2);
      // Reset in the middle of a multiply wait.
      cyc(1, 0, 1, 0, 0, 1, 2, 1, 1, 0);
      cyc(1, 0, 1, 0, 0, 1, 2, 1, 1, 0);
      cyc(0, 0, 1, 0, 0, 1, 2, 1, 1, 0);
      idle(3);
      // Random traffic; small register range makes dependencies frequent.
      for (int i = 0; i < 1500; i++) begin
         logic [4:0] rd, rn, rm;
         rd = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
         rn = ($urandom_range(0, 6) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
         rm = 5'($urandom_range(0, 3));
         cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0), rd, rn, rm,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0));
      end
      @(negedge clk);
      #1;
      chk("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
